relu_stream: RTL

- Parametrised successor to the single-lane `relu` activation block: multi-lane, valid/ready back-pressured, two-stage pipelined activation unit for the BNN datapath.
- Sits between the accumulator/batch-norm output and the binarisation/pooling stage.
- Supports three per-beat modes: plain ReLU, clipped ReLU (saturate at a programmable ceiling), and leaky ReLU (arithmetic right shift of negatives).
- Counts negative input elements for sparsity/debug statistics.

---
 rtl/bnn_act_pkg.sv | 17 +
 rtl/relu_lane.sv | 35 +++
 rtl/relu_stream.sv | 91 +++++++++
 3 files changed

// File: rtl/bnn_act_pkg.sv
// Shared definitions for the BNN activation datapath: mode encoding and
// lane packing helpers used by the activation blocks.
package bnn_act_pkg;

    typedef enum logic [1:0] {
        MODE_RELU   = 2'd0,
        MODE_CLIP   = 2'd1,
        MODE_LEAKY  = 2'd2,
        MODE_BYPASS = 2'd3
    } act_mode_t;

    // Lane i of a packed vector occupies bits [lane_lsb(i, w) +: w].
    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/relu_lane.sv
// Combinational single-lane activation: ReLU, clipped ReLU, leaky ReLU or
// bypass, plus a sign flag for the negative-element statistics.
module relu_lane
    import bnn_act_pkg::*;
#(
    parameter int W          = 32,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [W-1:0] x,
    input  act_mode_t           mode,
    input  logic signed [W-1:0] clip_max,
    output logic signed [W-1:0] y,
    output logic                is_neg
);

    always_comb begin
        is_neg = x[W-1];
        y      = x;
        case (mode)
            MODE_RELU:  y = is_neg ? '0 : x;
            MODE_CLIP: begin
                // A negative ceiling leaves an empty range, so everything maps to zero.
                if (clip_max[W-1] || is_neg)
                    y = '0;
                else if (x > clip_max)
                    y = clip_max;
                else
                    y = x;
            end
            MODE_LEAKY: y = is_neg ? (x >>> LEAK_SHIFT) : x;
            default:    y = x;
        endcase
    end

endmodule

// File: rtl/relu_stream.sv
// Multi-lane, valid/ready back-pressured, two-stage activation pipeline with a
// saturating count of negative input elements.
module relu_stream
    import bnn_act_pkg::*;
#(
    parameter int W          = 32,
    parameter int LANES      = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LANES*W-1:0]   din,
    input  logic                 ivalid,
    output logic                 iready,
    input  logic [1:0]           mode,
    input  logic [W-1:0]         clip_max,
    output logic [LANES*W-1:0]   dout,
    output logic                 ovalid,
    input  logic                 oready,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     neg_cnt
);

    localparam int NW = $clog2(LANES + 1);

    logic [LANES*W-1:0] res;
    logic [LANES-1:0]   neg;
    logic [NW-1:0]      beat_neg;
    logic [CNT_W:0]     cnt_sum;

    logic               s1_v, s2_v;
    logic [LANES*W-1:0] s1_d, s2_d;
    logic               s1_load, s2_load, accept;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        relu_lane #(
            .W          (W),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .x        (din[lane_lsb(i, W) +: W]),
            .mode     (act_mode_t'(mode)),
            .clip_max (clip_max),
            .y        (res[lane_lsb(i, W) +: W]),
            .is_neg   (neg[i])
        );
    end

    always_comb begin
        beat_neg = '0;
        for (int i = 0; i < LANES; i++)
            beat_neg = beat_neg + NW'(neg[i]);
    end

    // One extra bit catches the carry out so the counter can stick at all-ones.
    assign cnt_sum = {1'b0, neg_cnt} + (CNT_W+1)'(beat_neg);

    assign s2_load = ~s2_v | oready;
    assign s1_load = ~s1_v | s2_load;
    assign iready  = rst_n & s1_load;
    assign accept  = ivalid & iready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s1_d    <= '0;
            s2_d    <= '0;
            neg_cnt <= '0;
        end else begin
            if (s1_load) begin
                s1_v <= accept;
                if (accept)
                    s1_d <= res;
            end
            if (s2_load) begin
                s2_v <= s1_v;
                if (s1_v)
                    s2_d <= s1_d;
            end
            if (cnt_clr)
                neg_cnt <= accept ? CNT_W'(beat_neg) : '0;
            else if (accept)
                neg_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    assign dout   = s2_d;
    assign ovalid = s2_v;

endmodule
